// File: rtl/led_pattern_checker_if.sv
// Bundle for the LED pattern checker: observed bus and qualifiers in,
// lock/error status out.
interface led_pattern_checker_if #(
    parameter int WIDTH = 5,
    parameter int ERR_W = 8
);
    logic [WIDTH-1:0] led;
    logic             sample_en;
    logic             clear;
    logic             locked;
    logic             error;
    logic [ERR_W-1:0] err_cnt;
    logic             period_ok;

    modport master (
        output led, sample_en, clear,
        input  locked, error, err_cnt, period_ok
    );

    modport slave (
        input  led, sample_en, clear,
        output locked, error, err_cnt, period_ok
    );
endinterface

// File: rtl/led_pattern_checker.sv
// Receive-side checker for the LED dance pattern: hunts for the sync word,
// acquires lock, then flags every sample that deviates from the table.
module led_pattern_checker #(
    parameter int                     WIDTH    = 5,
    parameter int                     DEPTH    = 8,
    parameter logic [WIDTH*DEPTH-1:0] PATTERN  = 40'h1111041041,
    parameter int                     LOCK_LEN = 3,
    parameter int                     MAX_MISS = 2,
    parameter int                     ERR_W    = 8
) (
    input logic                  clk,
    input logic                  rst,
    led_pattern_checker_if.slave bus
);
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int RUN_W  = $clog2(LOCK_LEN + 1);
    localparam int MISS_W = $clog2(MAX_MISS + 1);
    localparam logic [WIDTH-1:0] SYNC_WORD = PATTERN[WIDTH-1:0];

    typedef enum logic [1:0] {HUNT, ACQUIRE, LOCKED} state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [RUN_W-1:0]  run_q, run_d;
    logic [MISS_W-1:0] miss_q, miss_d;
    logic              locked_q, locked_d;
    logic              error_q, error_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
    logic              period_ok_q, period_ok_d;
    logic              period_bad_q, period_bad_d;

    logic [WIDTH-1:0]  expected;
    logic              match;
    logic              last_entry;
    logic [ERR_W-1:0]  err_base;

    assign expected   = PATTERN[int'(idx_q)*WIDTH +: WIDTH];
    assign match      = (bus.led == expected);
    assign last_entry = (idx_q == IDX_W'(DEPTH - 1));
    // A mismatch in the same cycle as clear counts from zero, so it lands on 1.
    assign err_base   = bus.clear ? '0 : err_cnt_q;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        run_d        = run_q;
        miss_d       = miss_q;
        error_d      = 1'b0;
        period_ok_d  = 1'b0;
        period_bad_d = period_bad_q;
        err_cnt_d    = err_base;

        if (bus.sample_en) begin
            case (state_q)
                HUNT: begin
                    if (bus.led == SYNC_WORD) begin
                        state_d = ACQUIRE;
                        idx_d   = IDX_W'(1);
                        run_d   = RUN_W'(1);
                    end
                end
                ACQUIRE: begin
                    if (match) begin
                        idx_d = idx_q + IDX_W'(1);
                        run_d = run_q + RUN_W'(1);
                        if (int'(run_q) + 1 == LOCK_LEN) begin
                            state_d      = LOCKED;
                            miss_d       = '0;
                            period_bad_d = 1'b0;
                        end
                    end else begin
                        state_d = HUNT;
                        idx_d   = '0;
                        run_d   = '0;
                    end
                end
                LOCKED: begin
                    idx_d = idx_q + IDX_W'(1);
                    if (match) begin
                        miss_d = '0;
                        if (last_entry && !period_bad_q) begin
                            period_ok_d = 1'b1;
                        end
                    end else begin
                        error_d      = 1'b1;
                        err_cnt_d    = (&err_base) ? err_base : err_base + ERR_W'(1);
                        miss_d       = miss_q + MISS_W'(1);
                        period_bad_d = 1'b1;
                        if (int'(miss_q) + 1 == MAX_MISS) begin
                            state_d = HUNT;
                            idx_d   = '0;
                            run_d   = '0;
                            miss_d  = '0;
                        end
                    end
                    // The period boundary always starts the next period fresh.
                    if (last_entry) begin
                        period_bad_d = 1'b0;
                    end
                end
                default: begin
                    state_d = HUNT;
                    idx_d   = '0;
                    run_d   = '0;
                    miss_d  = '0;
                end
            endcase
        end

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= HUNT;
            idx_q        <= '0;
            run_q        <= '0;
            miss_q       <= '0;
            locked_q     <= 1'b0;
            error_q      <= 1'b0;
            err_cnt_q    <= '0;
            period_ok_q  <= 1'b0;
            period_bad_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            run_q        <= run_d;
            miss_q       <= miss_d;
            locked_q     <= locked_d;
            error_q      <= error_d;
            err_cnt_q    <= err_cnt_d;
            period_ok_q  <= period_ok_d;
            period_bad_q <= period_bad_d;
        end
    end

    assign bus.locked    = locked_q;
    assign bus.error     = error_q;
    assign bus.err_cnt   = err_cnt_q;
    assign bus.period_ok = period_ok_q;
endmodule

// File: tb/tb_led_pattern_checker.sv
// Bench for led_pattern_checker: table of stimulus/expected records run through
// a scoreboard queue, plus hand-written asynchronous reset checks.
module tb_led_pattern_checker;
    typedef struct {
        bit         sel;
        bit         en;
        logic [4:0] led;
        bit         clr;
        bit         lk;
        bit         er;
        logic [7:0] cnt;
        bit         pok;
        int         id;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [4:0] pat [8];
    vec_t       tbl [$];
    vec_t       expq [$];
    int         nChecks = 0;
    int         nFails  = 0;
    int         vecId   = 0;

    led_pattern_checker_if #(.WIDTH(5), .ERR_W(8)) bus1 ();
    led_pattern_checker_if #(.WIDTH(5), .ERR_W(2)) bus2 ();

    led_pattern_checker dut1 (.clk(clk), .rst(rst), .bus(bus1));
    led_pattern_checker #(.ERR_W(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkVal(input string name, input int id, input logic [7:0] act, input logic [7:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s (vec %0d): got %0h, expected %0h", name, id, act, exp);
        end
    endtask

    task automatic checkOutput(input vec_t e);
        if (e.sel) begin
            checkVal("locked",    e.id, 8'(bus2.locked),    8'(e.lk));
            checkVal("error",     e.id, 8'(bus2.error),     8'(e.er));
            checkVal("err_cnt",   e.id, 8'(bus2.err_cnt),   e.cnt);
            checkVal("period_ok", e.id, 8'(bus2.period_ok), 8'(e.pok));
        end else begin
            checkVal("locked",    e.id, 8'(bus1.locked),    8'(e.lk));
            checkVal("error",     e.id, 8'(bus1.error),     8'(e.er));
            checkVal("err_cnt",   e.id, bus1.err_cnt,       e.cnt);
            checkVal("period_ok", e.id, 8'(bus1.period_ok), 8'(e.pok));
        end
    endtask

    // Each posedge retires the record driven on the preceding negedge.
    always @(posedge clk) begin
        #1;
        if (expq.size() != 0) begin
            checkOutput(expq.pop_front());
        end
    end

    task automatic idleInputs();
        bus1.sample_en = 1'b0; bus1.clear = 1'b0; bus1.led = 5'b0;
        bus2.sample_en = 1'b0; bus2.clear = 1'b0; bus2.led = 5'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        bus1.sample_en = !v.sel && v.en;
        bus1.clear     = !v.sel && v.clr;
        bus1.led       = v.led;
        bus2.sample_en = v.sel && v.en;
        bus2.clear     = v.sel && v.clr;
        bus2.led       = v.led;
        expq.push_back(v);
    endtask

    task automatic addVec(input bit sel, input bit en, input logic [4:0] led, input bit clr,
                          input bit lk, input bit er, input logic [7:0] cnt, input bit pok);
        vec_t v;
        v.sel = sel; v.en = en; v.led = led; v.clr = clr;
        v.lk = lk; v.er = er; v.cnt = cnt; v.pok = pok; v.id = vecId;
        vecId++;
        tbl.push_back(v);
    endtask

    task automatic runTable();
        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i]);
        end
        tbl.delete();
    endtask

    task automatic checkAllZero(input int id);
        checkVal("rst_locked1", id, 8'(bus1.locked),    8'd0);
        checkVal("rst_error1",  id, 8'(bus1.error),     8'd0);
        checkVal("rst_cnt1",    id, bus1.err_cnt,       8'd0);
        checkVal("rst_pok1",    id, 8'(bus1.period_ok), 8'd0);
        checkVal("rst_locked2", id, 8'(bus2.locked),    8'd0);
        checkVal("rst_cnt2",    id, 8'(bus2.err_cnt),   8'd0);
        checkVal("rst_error2",  id, 8'(bus2.error),     8'd0);
    endtask

    task automatic doReset(input int id);
        @(negedge clk);
        rst = 1'b1;
        idleInputs();
        #2;
        checkAllZero(id);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        pat = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b01000, 5'b00100, 5'b00010};
        rst = 1'b1;
        idleInputs();
        doReset(-1);

        // Clean lock and two clean periods.
        addVec(0, 1, pat[0], 0, 0, 0, 0, 0);
        addVec(0, 1, pat[1], 0, 0, 0, 0, 0);
        addVec(0, 1, pat[2], 0, 1, 0, 0, 0);
        for (int i = 3; i < 8; i++) addVec(0, 1, pat[i], 0, 1, 0, 0, i == 7);
        for (int i = 0; i < 8; i++) addVec(0, 1, pat[i], 0, 1, 0, 0, i == 7);
        // Single glitch spoils one period only.
        for (int i = 0; i < 8; i++)
            addVec(0, 1, (i == 4) ? 5'b10001 : pat[i], 0, 1, i == 4, (i >= 4) ? 8'd1 : 8'd0, 0);
        for (int i = 0; i < 8; i++) addVec(0, 1, pat[i], 0, 1, 0, 1, i == 7);
        // Gaps with garbage on the bus are ignored.
        addVec(0, 1, pat[0], 0, 1, 0, 1, 0);
        addVec(0, 1, pat[1], 0, 1, 0, 1, 0);
        for (int i = 0; i < 4; i++) addVec(0, 0, 5'b11111, 0, 1, 0, 1, 0);
        for (int i = 2; i < 8; i++) addVec(0, 1, pat[i], 0, 1, 0, 1, i == 7);
        // Clear while idle, then two misses drop lock.
        addVec(0, 0, 5'b11111, 1, 1, 0, 0, 0);
        addVec(0, 1, 5'b11111, 0, 1, 1, 1, 0);
        addVec(0, 1, 5'b11111, 0, 0, 1, 2, 0);
        addVec(0, 1, pat[2],   0, 0, 0, 2, 0);
        // Acquisition aborted by an out-of-order entry, then re-lock.
        addVec(0, 1, pat[0], 0, 0, 0, 2, 0);
        addVec(0, 1, pat[1], 0, 0, 0, 2, 0);
        addVec(0, 1, pat[3], 0, 0, 0, 2, 0);
        addVec(0, 1, pat[0], 0, 0, 0, 2, 0);
        addVec(0, 1, pat[1], 0, 0, 0, 2, 0);
        addVec(0, 1, pat[2], 0, 1, 0, 2, 0);
        // Isolated misses up to 5, then clear coincident with a mismatch.
        addVec(0, 1, 5'b11111, 0, 1, 1, 3, 0);
        addVec(0, 1, pat[4],   0, 1, 0, 3, 0);
        addVec(0, 1, 5'b11111, 0, 1, 1, 4, 0);
        addVec(0, 1, pat[6],   0, 1, 0, 4, 0);
        addVec(0, 1, 5'b11111, 0, 1, 1, 5, 0);
        addVec(0, 1, pat[0],   0, 1, 0, 5, 0);
        addVec(0, 1, 5'b11111, 1, 1, 1, 1, 0);
        addVec(0, 1, pat[2],   0, 1, 0, 1, 0);
        addVec(0, 1, pat[3],   1, 1, 0, 0, 0);
        for (int i = 4; i < 8; i++) addVec(0, 1, pat[i], 0, 1, 0, 0, 0);
        for (int i = 0; i < 8; i++) addVec(0, 1, pat[i], 0, 1, 0, 0, i == 7);
        runTable();

        // Late start: HUNT ignores everything before the sync word.
        doReset(-2);
        for (int i = 3; i < 8; i++) addVec(0, 1, pat[i], 0, 0, 0, 0, 0);
        addVec(0, 1, pat[0], 0, 0, 0, 0, 0);
        addVec(0, 1, pat[1], 0, 0, 0, 0, 0);
        addVec(0, 1, pat[2], 0, 1, 0, 0, 0);
        addVec(0, 1, pat[3], 0, 1, 0, 0, 0);
        runTable();

        // Saturation on the 2-bit counter instance.
        doReset(-3);
        addVec(1, 1, pat[0],   0, 0, 0, 0, 0);
        addVec(1, 1, pat[1],   0, 0, 0, 0, 0);
        addVec(1, 1, pat[2],   0, 1, 0, 0, 0);
        addVec(1, 1, 5'b11111, 0, 1, 1, 1, 0);
        addVec(1, 1, pat[4],   0, 1, 0, 1, 0);
        addVec(1, 1, 5'b11111, 0, 1, 1, 2, 0);
        addVec(1, 1, pat[6],   0, 1, 0, 2, 0);
        addVec(1, 1, 5'b11111, 0, 1, 1, 3, 0);
        addVec(1, 1, pat[0],   0, 1, 0, 3, 0);
        addVec(1, 1, 5'b11111, 0, 1, 1, 3, 0);
        addVec(1, 1, pat[2],   0, 1, 0, 3, 0);
        addVec(1, 1, 5'b11111, 0, 1, 1, 3, 0);
        runTable();

        // Asynchronous reset between edges while an error pulse is high.
        @(posedge clk);
        #3;
        checkVal("pre_rst_error2",  -4, 8'(bus2.error),  8'd1);
        checkVal("pre_rst_locked2", -4, 8'(bus2.locked), 8'd1);
        rst = 1'b1;
        #1;
        checkAllZero(-4);
        @(negedge clk);
        rst = 1'b0;
        idleInputs();
        repeat (2) @(negedge clk);
        checkVal("queue_empty", -5, 8'(expq.size()), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule

// File: doc/led_pattern_checker.md
Name: led_pattern_checker

Overview:
- Receive-side counterpart of the LED "dance" pattern generator.
- Samples the 5-bit led bus on qualified cycles and locks onto the repeating pattern.
- Checks every subsequent sample against a built-in expected-pattern table, then reports lock status, per-sample error pulses, a saturating error count and a per-period "clean pass" pulse.
- Used as a synthesisable self-checker beside the top-level LED driver and as a bench monitor.

Parameters:
WIDTH, 5, bits per pattern entry (led bus width)
DEPTH, 8, entries per pattern period (power of 2)
PATTERN, 40'h1111041041, entry i = PATTERN[i*WIDTH +: WIDTH]; default sequence 00001,00010,00100,01000,10000,01000,00100,00010
LOCK_LEN, 3, consecutive in-order matches (sync entry included) required to declare lock
MAX_MISS, 2, consecutive mismatches while locked that drop lock
ERR_W, 8, error counter width

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state
led  input  WIDTH  observed LED bus
sample_en  input  1  qualifies led for the current cycle; no state change when low
clear  input  1  synchronous clear of err_cnt
locked  output  1  high while in LOCKED
error  output  1  one-cycle pulse per mismatching sample while LOCKED
err_cnt  output  ERR_W  saturating count of error pulses
period_ok  output  1  one-cycle pulse when a full LOCKED period completes with zero mismatches

Behaviour:
- Reset is asynchronous and active-high. Reset values: state=HUNT, idx=0, run=0, miss=0, locked=0, error=0, err_cnt=0, period_ok=0, period_bad=0.
- All outputs are registered. A sample taken at edge k is reflected in outputs after edge k (latency 1).
- error and period_ok are single-cycle pulses and are low whenever sample_en is low.
- Entry 0 is the sync word; it must be unique within PATTERN (the default is).
- HUNT:
  - If sample_en and led==P[0]: go to ACQUIRE, idx=1, run=1.
  - Otherwise stay in HUNT. No errors are counted.
- ACQUIRE:
  - On a sample with led==P[idx]: idx=idx+1 (mod DEPTH), run=run+1.
  - If run+1==LOCK_LEN: go to LOCKED, miss=0, period_bad=0.
  - On a mismatch: go to HUNT, idx=0, run=0. No error pulse.
- LOCKED (locked=1):
  - Every sample advances idx by 1 mod DEPTH, whether it matches or not.
  - On a match: miss=0.
  - On a mismatch: error=1, err_cnt+1 (saturating at all-ones), miss+1, period_bad=1.
  - If miss+1==MAX_MISS: go to HUNT, idx=0, locked=0 after the same edge. The error pulse for that sample is still issued.
  - On a sample at idx==DEPTH-1 that matches with period_bad==0: period_ok=1.
  - Every sample at idx==DEPTH-1 clears period_bad.
  - The first LOCKED period starts at whatever idx lock occurred on. It is judged only from lock onward.
- clear:
  - Sets err_cnt to 0.
  - If a mismatch occurs in the same cycle, err_cnt=1 (increment wins over clear).
  - clear does not affect state, idx or locked.
- Wrap-around: idx is log2(DEPTH) bits and wraps naturally from DEPTH-1 to 0.
- Reset mid-operation: immediate return to reset values regardless of state. Pulses drop asynchronously.
- Gaps: sample_en low for any number of cycles freezes state, idx, run and miss.

Test Plan:
- Clean lock:
  - Stimulus: reset, then drive the default sequence starting 00001 with sample_en=1 continuously.
  - Response: locked rises after the 3rd sample (00100). period_ok pulses after each later 00010 sample. err_cnt stays 0.
- Late start:
  - Stimulus: begin streaming at entry 3 (01000).
  - Response: HUNT ignores 01000,10000,01000,00100,00010. Lock is acquired after 00001,00010,00100. err_cnt=0.
- Single glitch:
  - Stimulus: while locked, replace one 10000 with 10001.
  - Response: exactly one error pulse, err_cnt=1, locked stays 1. No period_ok for that period. period_ok returns on the next period.
- Loss of lock:
  - Stimulus: two consecutive corrupted samples (11111,11111) while locked.
  - Response: two error pulses, err_cnt=2, locked=0 after the second. Re-lock occurs after the next 00001,00010,00100.
- Gaps and clear:
  - Stimulus: insert 4-cycle sample_en=0 gaps mid-pattern; then assert clear in the same cycle as a mismatch with err_cnt=5.
  - Response: gaps cause no errors and no idx change. err_cnt becomes 1.
- Saturation and reset:
  - Stimulus: with ERR_W=2, force 5 isolated mismatches, spaced so lock is held. Then pulse reset asynchronously between clock edges.
  - Response: err_cnt holds at 3. Reset immediately drives locked=0 and err_cnt=0.
